clk_rst_sequencer: RTL and testbench

CLK_RST_SEQUENCER -- requirements
Module: clk_rst_sequencer

---
 rtl/clk_rst_sequencer.sv | 129 ++++++++++++
 tb/tb_clk_rst_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_sequencer.sv
// Bring-up sequencer for a clock wizard: resets it, qualifies its lock, then
// releases the system reset. It retries failed lock attempts and drops to FAIL
// once the retry limit is reached.
module clk_rst_sequencer #(
  parameter int WIZ_RST_CYCLES     = 8,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_DELAY      = 16,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       locked,
  input  logic       sw_reset_req,
  output logic       wiz_resetn,
  output logic       sys_reset,
  output logic [2:0] state,
  output logic       error,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_A   = (WIZ_RST_CYCLES > LOCK_TIMEOUT) ? WIZ_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B   = (LOCK_STABLE_CYCLES > RELEASE_DELAY) ? LOCK_STABLE_CYCLES : RELEASE_DELAY;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int RW      = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    S_WIZ_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAIL      = 3'd5
  } state_t;

  state_t        st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [RW-1:0] retry_cnt, retry_nxt;
  logic [7:0]    llc_nxt;
  logic          lock_meta, locked_s;
  logic          fail_attempt;

  // Two-flop synchronizer; only locked_s feeds decisions.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= locked;
      locked_s  <= lock_meta;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st              <= S_WIZ_RST;
      cnt             <= '0;
      retry_cnt       <= '0;
      lock_loss_count <= 8'd0;
      wiz_resetn      <= 1'b0;
      sys_reset       <= 1'b1;
      error           <= 1'b0;
    end else begin
      st              <= st_nxt;
      cnt             <= cnt_nxt;
      retry_cnt       <= retry_nxt;
      lock_loss_count <= llc_nxt;
      // Outputs are decoded from the next state so they line up with st.
      wiz_resetn      <= (st_nxt != S_WIZ_RST);
      sys_reset       <= (st_nxt != S_RUN);
      error           <= (st_nxt == S_FAIL);
    end
  end

  always_comb begin
    st_nxt       = st;
    cnt_nxt      = cnt + 1'b1;
    retry_nxt    = retry_cnt;
    llc_nxt      = lock_loss_count;
    fail_attempt = 1'b0;
    case (st)
      S_WIZ_RST: begin
        if (cnt == CW'(WIZ_RST_CYCLES - 1)) st_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s)                            st_nxt = S_STABLE;
        else if (cnt == CW'(LOCK_TIMEOUT - 1))   fail_attempt = 1'b1;
      end
      S_STABLE: begin
        if (!locked_s)                                fail_attempt = 1'b1;
        else if (cnt == CW'(LOCK_STABLE_CYCLES - 1))  st_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!locked_s) fail_attempt = 1'b1;
        else if (cnt == CW'(RELEASE_DELAY - 1)) begin
          st_nxt    = S_RUN;
          retry_nxt = '0;
        end
      end
      S_RUN: begin
        cnt_nxt = cnt;
        // Lock loss outranks a coincident software request.
        if (!locked_s) begin
          st_nxt = S_WIZ_RST;
          if (lock_loss_count != 8'hFF) llc_nxt = lock_loss_count + 8'd1;
        end else if (sw_reset_req) begin
          st_nxt = S_RELEASE;
        end
      end
      S_FAIL: begin
        cnt_nxt = cnt;
        if (sw_reset_req) begin
          st_nxt    = S_WIZ_RST;
          retry_nxt = '0;
        end
      end
      default: st_nxt = S_WIZ_RST;
    endcase
    if (fail_attempt) begin
      retry_nxt = retry_cnt + 1'b1;
      st_nxt    = (retry_nxt == RW'(MAX_RETRIES)) ? S_FAIL : S_WIZ_RST;
    end
    if (st_nxt != st) cnt_nxt = '0;
  end

  assign state = st;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench for clk_rst_sequencer: stimulus queues the expected state
// transitions (with dwell times); a negedge monitor checks them and the outputs.
module tb_clk_rst_sequencer;

  logic       clock, reset, locked, sw_reset_req;
  logic       wiz_resetn, sys_reset, error;
  logic [2:0] state;
  logic [7:0] lock_loss_count;

  int checks = 0;
  int errors = 0;

  clk_rst_sequencer #(
    .WIZ_RST_CYCLES(3), .LOCK_TIMEOUT(20), .LOCK_STABLE_CYCLES(8),
    .RELEASE_DELAY(4), .MAX_RETRIES(2)
  ) dut (
    .clock(clock), .reset(reset), .locked(locked), .sw_reset_req(sw_reset_req),
    .wiz_resetn(wiz_resetn), .sys_reset(sys_reset), .state(state),
    .error(error), .lock_loss_count(lock_loss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] st;
    int         dwell;   // cycles spent in the previous state; -1 = unchecked
    logic [7:0] llc;
  } exp_t;

  exp_t q[$];

  task automatic push(input logic [2:0] st, input int dwell, input logic [7:0] llc);
    exp_t e;
    e.st = st; e.dwell = dwell; e.llc = llc;
    q.push_back(e);
  endtask

  // Monitor: pops one record per observed state change; checks outputs every cycle.
  initial begin
    logic [2:0] prev;
    logic [2:0] cur_st;
    logic [7:0] cur_llc;
    int         dwell;
    exp_t       e;
    prev = 3'd0; cur_st = 3'd0; cur_llc = 8'd0; dwell = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 3'd0; cur_st = 3'd0; cur_llc = 8'd0; dwell = 0;
        continue;
      end
      if (state !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_transition: got state %0d from %0d, expected none", state, prev);
        end else begin
          e = q.pop_front();
          if (state !== e.st || (e.dwell >= 0 && dwell != e.dwell) || lock_loss_count !== e.llc) begin
            errors++;
            $display("FAIL transition: got state=%0d dwell=%0d llc=%0d, expected state=%0d dwell=%0d llc=%0d",
                     state, dwell, lock_loss_count, e.st, e.dwell, e.llc);
          end
          cur_st = e.st; cur_llc = e.llc;
        end
        prev  = state;
        dwell = 1;
      end else begin
        dwell++;
      end
      checks++;
      if (sys_reset !== (cur_st != 3'd4) || wiz_resetn !== (cur_st != 3'd0) ||
          error !== (cur_st == 3'd5) || lock_loss_count !== cur_llc) begin
        errors++;
        $display("FAIL outputs: got sys_reset=%b wiz_resetn=%b error=%b llc=%0d, expected for state %0d llc=%0d",
                 sys_reset, wiz_resetn, error, lock_loss_count, cur_st, cur_llc);
      end
    end
  end

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (state !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (state !== s) begin
      checks++;
      errors++;
      $display("FAIL wait_state: got state %0d after %0d cycles, expected %0d", state, n, s);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (state !== 3'd0 || wiz_resetn !== 1'b0 || sys_reset !== 1'b1 ||
        error !== 1'b0 || lock_loss_count !== 8'd0) begin
      errors++;
      $display("FAIL %s: got state=%0d wiz_resetn=%b sys_reset=%b error=%b llc=%0d, expected 0 0 1 0 0",
               name, state, wiz_resetn, sys_reset, error, lock_loss_count);
    end
  endtask

  // One-cycle drop of locked while in RUN.
  task automatic lock_drop();
    @(posedge clock); #2 locked = 1'b0;
    @(posedge clock); #2 locked = 1'b1;
  endtask

  initial begin
    int llc_exp;
    reset = 1'b1; locked = 1'b0; sw_reset_req = 1'b0;
    repeat (3) @(posedge clock);
    #1 check_reset_outputs("reset_state");

    // Clean bring-up.
    push(3'd1, 3, 8'd0); push(3'd2, 5, 8'd0); push(3'd3, 8, 8'd0); push(3'd4, 4, 8'd0);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    #2 locked = 1'b1;
    wait_state(3'd4, 100);

    // Software reset in RUN re-runs RELEASE only.
    push(3'd3, -1, 8'd0); push(3'd4, 4, 8'd0);
    @(posedge clock); #2 sw_reset_req = 1'b1;
    @(posedge clock); #2 sw_reset_req = 1'b0;
    wait_state(3'd4, 50);

    // Software request coincident with lock loss: lock loss wins.
    push(3'd0, -1, 8'd1); push(3'd1, 3, 8'd1); push(3'd2, 1, 8'd1);
    push(3'd3, 8, 8'd1); push(3'd4, 4, 8'd1);
    @(posedge clock); #2 locked = 1'b0;
    @(posedge clock); #2 locked = 1'b1;
    @(posedge clock); #2 sw_reset_req = 1'b1;
    @(posedge clock); #2 sw_reset_req = 1'b0;
    wait_state(3'd4, 100);

    // Repeated lock losses saturate the counter at 255.
    llc_exp = 1;
    for (int i = 0; i < 256; i++) begin
      llc_exp = (llc_exp < 255) ? llc_exp + 1 : 255;
      push(3'd0, -1, 8'(llc_exp)); push(3'd1, 3, 8'(llc_exp)); push(3'd2, 1, 8'(llc_exp));
      push(3'd3, 8, 8'(llc_exp)); push(3'd4, 4, 8'(llc_exp));
      lock_drop();
      wait_state(3'd0, 10);
      wait_state(3'd4, 100);
    end

    // Glitch after 5 stable cycles, then a second failure exhausts the retries.
    push(3'd0, -1, 8'd255); push(3'd1, 3, 8'd255); push(3'd2, 1, 8'd255);
    push(3'd0, 6, 8'd255);  push(3'd1, 3, 8'd255); push(3'd2, 1, 8'd255);
    push(3'd5, 4, 8'd255);
    lock_drop();
    wait_state(3'd2, 50);
    repeat (3) @(posedge clock);
    #2 locked = 1'b0;
    @(posedge clock); #2 locked = 1'b1;
    wait_state(3'd0, 20);
    wait_state(3'd2, 50);
    @(posedge clock); #2 locked = 1'b0;
    wait_state(3'd5, 20);

    // FAIL holds until software reset; then two timeouts with no lock.
    push(3'd0, 11, 8'd255); push(3'd1, 3, 8'd255); push(3'd0, 20, 8'd255);
    push(3'd1, 3, 8'd255);  push(3'd5, 20, 8'd255);
    repeat (10) @(posedge clock);
    #2 sw_reset_req = 1'b1;
    @(posedge clock); #2 sw_reset_req = 1'b0;
    wait_state(3'd5, 100);

    // Recover from FAIL with lock present, then reset asynchronously in RELEASE.
    push(3'd0, 11, 8'd255); push(3'd1, 3, 8'd255); push(3'd2, 1, 8'd255); push(3'd3, 8, 8'd255);
    repeat (10) @(posedge clock);
    #2 sw_reset_req = 1'b1;
    @(posedge clock); #2 sw_reset_req = 1'b0; locked = 1'b1;
    wait_state(3'd3, 50);
    push(3'd0, -1, 8'd0); push(3'd1, 3, 8'd0); push(3'd2, 1, 8'd0);
    push(3'd3, 8, 8'd0);  push(3'd4, 4, 8'd0);
    @(posedge clock); #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    #1 reset = 1'b0;
    wait_state(3'd4, 100);

    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending transitions, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
